mio_bus_responder: RTL and testbench

MIO_BUS_RESPONDER -- requirements
Module: mio_bus_responder

---
 rtl/mio_bus_responder.sv | 212 +++++++++++++++++++++
 tb/tb_mio_bus_responder.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mio_bus_responder.sv
// CPU bus responder: routes word accesses either to an external synchronous RAM
// or to a small IO block (LED/switch port plus a countdown timer with interrupt).
module mio_bus_responder #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        breq_i,
  input  logic        mem_w,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_from_cpu,
  output logic [31:0] data_to_cpu,
  output logic        MIO_ready,
  output logic [9:0]  ram_addr,
  output logic [31:0] ram_din,
  output logic        ram_we,
  input  logic [31:0] ram_dout,
  input  logic [15:0] switch_in,
  output logic [15:0] led_out,
  output logic        Ireq,
  input  logic        Iack
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAM_WAIT = 2'd1,
    DONE     = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_CYCLES - 1);
  localparam logic [1:0] OFF_LED    = 2'd0;
  localparam logic [1:0] OFF_COUNT  = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  state_t      state_q, state_d;
  logic [9:0]  word_addr_q, word_addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic        io_q, io_d;
  logic [3:0]  wait_q, wait_d;
  logic        ready_q, ready_d;
  logic        we_q, we_d;
  logic [31:0] io_rdata_q, io_rdata_d;

  logic [15:0] led_q, led_d;
  logic [31:0] count_q, count_d;
  logic [31:0] reload_q, reload_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        pending_q, pending_d;

  logic        req_io;
  logic        io_wr;
  logic [1:0]  io_off;
  logic [31:0] io_read_val;
  logic        timer_set;
  logic        pending_clr;
  logic        unused_addr_bits;

  assign req_io           = (addr_in[31:28] == 4'hF);
  assign io_off           = addr_in[3:2];
  assign io_wr            = (state_q == IDLE) && breq_i && req_io && mem_w;
  assign unused_addr_bits = ^{addr_in[27:12], addr_in[1:0]};

  always_comb begin
    io_read_val = '0;
    case (io_off)
      OFF_LED:    io_read_val = {16'b0, switch_in};
      OFF_COUNT:  io_read_val = count_q;
      OFF_CTRL:   io_read_val = {30'b0, ctrl_q};
      OFF_STATUS: io_read_val = {31'b0, pending_q};
      default:    io_read_val = '0;
    endcase
  end

  // IO requests complete on the capture edge; RAM requests wait WAIT_CYCLES first.
  always_comb begin
    state_d     = state_q;
    word_addr_d = word_addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    io_d        = io_q;
    wait_d      = wait_q;
    ready_d     = 1'b0;
    we_d        = 1'b0;
    io_rdata_d  = '0;
    case (state_q)
      IDLE: begin
        if (breq_i) begin
          word_addr_d = addr_in[11:2];
          wdata_d     = data_from_cpu;
          wr_d        = mem_w;
          io_d        = req_io;
          if (req_io) begin
            state_d = DONE;
            ready_d = 1'b1;
            if (!mem_w) begin
              io_rdata_d = io_read_val;
            end
          end else begin
            state_d = RAM_WAIT;
            wait_d  = WAIT_LOAD;
            we_d    = mem_w;
          end
        end
      end
      RAM_WAIT: begin
        if (wait_q == 4'd0) begin
          state_d = DONE;
          ready_d = 1'b1;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A count write reloads both registers and suppresses that cycle's decrement.
  always_comb begin
    led_d     = led_q;
    ctrl_d    = ctrl_q;
    count_d   = count_q;
    reload_d  = reload_q;
    timer_set = 1'b0;
    if (io_wr && (io_off == OFF_COUNT)) begin
      count_d  = data_from_cpu;
      reload_d = data_from_cpu;
    end else if (ctrl_q[0]) begin
      if (count_q != 32'd0) begin
        count_d   = count_q - 32'd1;
        timer_set = (count_q == 32'd1);
      end else if (ctrl_q[1]) begin
        count_d = reload_q;
      end
    end
    if (io_wr && (io_off == OFF_LED)) begin
      led_d = data_from_cpu[15:0];
    end
    if (io_wr && (io_off == OFF_CTRL)) begin
      ctrl_d = data_from_cpu[1:0];
    end
    pending_clr = Iack || (io_wr && (io_off == OFF_STATUS) && data_from_cpu[0]);
    if (timer_set) begin
      pending_d = 1'b1;
    end else if (pending_clr) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      word_addr_q <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      io_q        <= 1'b0;
      wait_q      <= '0;
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      io_rdata_q  <= '0;
      led_q       <= '0;
      count_q     <= '0;
      reload_q    <= '0;
      ctrl_q      <= '0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_addr_q <= word_addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      io_q        <= io_d;
      wait_q      <= wait_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      io_rdata_q  <= io_rdata_d;
      led_q       <= led_d;
      count_q     <= count_d;
      reload_q    <= reload_d;
      ctrl_q      <= ctrl_d;
      pending_q   <= pending_d;
    end
  end

  assign MIO_ready = ready_q;
  assign ram_we    = we_q;
  assign ram_addr  = word_addr_q;
  assign ram_din   = wdata_q;
  assign led_out   = led_q;
  assign Ireq      = pending_q;

  // ram_dout is the RAM's own output register; holding ram_addr through DONE keeps
  // it valid there even when WAIT_CYCLES is 1.
  always_comb begin
    data_to_cpu = '0;
    if (ready_q) begin
      if (io_q) begin
        data_to_cpu = io_rdata_q;
      end else if (!wr_q) begin
        data_to_cpu = ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed plus randomized bench for mio_bus_responder, checked against a
// transaction-level model (memory array, LED shadow, timer expiry arithmetic).
module tb_mio_bus_responder;

  localparam int WAIT_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        breq_i = 1'b0;
  logic        mem_w = 1'b0;
  logic [31:0] addr_in = '0;
  logic [31:0] data_from_cpu = '0;
  logic [31:0] data_to_cpu;
  logic        MIO_ready;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic [31:0] ram_dout;
  logic [15:0] switch_in = '0;
  logic [15:0] led_out;
  logic        Ireq;
  logic        Iack = 1'b0;

  int compareCount = 0;
  int failCount = 0;
  int cyc = 0;
  int lastReadyCyc = 0;

  logic [31:0] ramArray [0:1023];
  logic [31:0] refMem [0:1023];

  mio_bus_responder #(.WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk),
    .reset(reset),
    .breq_i(breq_i),
    .mem_w(mem_w),
    .addr_in(addr_in),
    .data_from_cpu(data_from_cpu),
    .data_to_cpu(data_to_cpu),
    .MIO_ready(MIO_ready),
    .ram_addr(ram_addr),
    .ram_din(ram_din),
    .ram_we(ram_we),
    .ram_dout(ram_dout),
    .switch_in(switch_in),
    .led_out(led_out),
    .Ireq(Ireq),
    .Iack(Iack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External synchronous RAM with one cycle of read latency.
  initial begin
    for (int i = 0; i < 1024; i++) ramArray[i] = '0;
  end

  always @(posedge clk) begin
    if (ram_we) ramArray[ram_addr] <= ram_din;
    ram_dout <= ramArray[ram_addr];
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic int expLatency(input logic [31:0] addr);
    return (addr[31:28] == 4'hF) ? 1 : WAIT_CYCLES + 1;
  endfunction

  // One complete CPU transaction; checks latency, idle data, pulse width and ram_we.
  task automatic applyStimulus(input string tag, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata);
    int lat;
    int weCount;
    logic got;
    logic [9:0] weAddr;
    lat = 0;
    weCount = 0;
    got = 1'b0;
    weAddr = '0;
    rdata = '0;
    @(negedge clk);
    breq_i = 1'b1;
    mem_w = wr;
    addr_in = addr;
    data_from_cpu = wdata;
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (ram_we) begin
        weCount++;
        weAddr = ram_addr;
      end
      if (MIO_ready) begin
        got = 1'b1;
        rdata = data_to_cpu;
        lastReadyCyc = cyc;
      end else begin
        checkOutput({tag, "_data_idle"}, data_to_cpu, 32'h0);
      end
    end
    breq_i = 1'b0;
    checkOutput({tag, "_ready"}, 32'(got), 32'h1);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLatency(addr)));
    checkOutput({tag, "_we_pulses"}, 32'(weCount), (wr && addr[31:28] != 4'hF) ? 32'h1 : 32'h0);
    if (wr && addr[31:28] != 4'hF) checkOutput({tag, "_we_addr"}, 32'(weAddr), 32'(addr[11:2]));
    @(posedge clk);
    #1;
    checkOutput({tag, "_ready_width"}, 32'(MIO_ready), 32'h0);
    checkOutput({tag, "_data_after"}, data_to_cpu, 32'h0);
  endtask

  task automatic waitIreq(input string tag, input int expCyc);
    int n;
    n = 0;
    while (!Ireq && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_ireq"}, 32'(Ireq), 32'h1);
    checkOutput({tag, "_ireq_cycle"}, 32'(cyc), 32'(expCyc));
  endtask

  task automatic pulseIack(input string tag);
    @(negedge clk);
    Iack = 1'b1;
    @(posedge clk);
    #1;
    Iack = 1'b0;
    checkOutput({tag, "_ireq_cleared"}, 32'(Ireq), 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] d;
    logic [15:0] sw;
    logic [9:0]  idx;
    logic [1:0]  off;
    int op;
    int nCount;
    int cE;
    int cW;
    int sumBad;
    int pulseCyc [2];
    logic [31:0] pulseData [2];
    int seen;

    for (int i = 0; i < 1024; i++) refMem[i] = '0;

    // Reset state
    #1;
    checkOutput("rst_ready", 32'(MIO_ready), 32'h0);
    checkOutput("rst_data", data_to_cpu, 32'h0);
    checkOutput("rst_we", 32'(ram_we), 32'h0);
    checkOutput("rst_ram_addr", 32'(ram_addr), 32'h0);
    checkOutput("rst_ram_din", ram_din, 32'h0);
    checkOutput("rst_led", 32'(led_out), 32'h0);
    checkOutput("rst_ireq", 32'(Ireq), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // LED write and RAM write/read
    applyStimulus("led_wr", 1'b1, 32'hF000_0000, 32'h0000_A5A5, rd);
    checkOutput("led_out", 32'(led_out), 32'h0000_A5A5);
    applyStimulus("ram_wr", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd);
    refMem[4] = 32'hDEAD_BEEF;
    applyStimulus("ram_rd", 1'b0, 32'h0000_0010, 32'h0, rd);
    checkOutput("ram_rd_data", rd, refMem[4]);

    // Randomized RAM / LED / switch traffic
    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 3);
      idx = 10'($urandom_range(0, 31));
      d = $urandom;
      if (op < 2) begin
        a = {4'($urandom_range(0, 14)), 16'($urandom), idx, 2'($urandom)};
        if (op == 0) begin
          applyStimulus("rnd_ram_wr", 1'b1, a, d, rd);
          refMem[idx] = d;
        end else begin
          applyStimulus("rnd_ram_rd", 1'b0, a, d, rd);
          checkOutput("rnd_ram_rd_data", rd, refMem[idx]);
        end
      end else begin
        off = 2'd0;
        a = {4'hF, 24'($urandom), off, 2'($urandom)};
        if (op == 2) begin
          applyStimulus("rnd_led_wr", 1'b1, a, d, rd);
          checkOutput("rnd_led_out", 32'(led_out), {16'h0, d[15:0]});
        end else begin
          sw = 16'($urandom);
          switch_in = sw;
          applyStimulus("rnd_sw_rd", 1'b0, a, d, rd);
          checkOutput("rnd_sw_data", rd, {16'h0, sw});
        end
      end
    end

    // One-shot timer: count 5, then enable
    applyStimulus("os_count_wr", 1'b1, 32'hF000_0004, 32'd5, rd);
    applyStimulus("os_ctrl_wr", 1'b1, 32'hF000_0008, 32'd1, rd);
    cE = lastReadyCyc;
    checkOutput("os_ireq_early", 32'(Ireq), 32'h0);
    waitIreq("os", cE + 5);
    applyStimulus("os_count_rd", 1'b0, 32'hF000_0004, 32'h0, rd);
    checkOutput("os_count_zero", rd, 32'h0);

    // Back-to-back status reads with breq_i held high
    @(negedge clk);
    breq_i = 1'b1;
    mem_w = 1'b0;
    addr_in = 32'hF000_000C;
    seen = 0;
    pulseCyc[0] = 0;
    pulseCyc[1] = 0;
    pulseData[0] = '0;
    pulseData[1] = '0;
    for (int k = 0; k < 10 && seen < 2; k++) begin
      @(posedge clk);
      #1;
      if (MIO_ready) begin
        pulseCyc[seen] = cyc;
        pulseData[seen] = data_to_cpu;
        seen++;
      end
    end
    breq_i = 1'b0;
    checkOutput("b2b_pulses", 32'(seen), 32'd2);
    checkOutput("b2b_gap", 32'(pulseCyc[1] - pulseCyc[0]), 32'd2);
    checkOutput("b2b_data0", pulseData[0], 32'h1);
    checkOutput("b2b_data1", pulseData[1], 32'h1);
    @(posedge clk);
    #1;
    pulseIack("os_iack");

    // Randomized one-shot reloads while enabled; the load edge does not decrement
    for (int i = 0; i < 3; i++) begin
      nCount = $urandom_range(6, 30);
      applyStimulus("rt_count_wr", 1'b1, 32'hF000_0004, 32'(nCount), rd);
      cW = lastReadyCyc;
      applyStimulus("rt_count_rd", 1'b0, 32'hF000_0004, 32'h0, rd);
      checkOutput("rt_count_val", rd, 32'(nCount - (lastReadyCyc - cW - 1)));
      waitIreq("rt", cW + nCount);
      applyStimulus("rt_status_rd", 1'b0, 32'hF000_000C, 32'h0, rd);
      checkOutput("rt_status", rd, 32'h1);
      pulseIack("rt_iack");
    end

    // Auto-reload: count 3, ctrl 3
    applyStimulus("ar_ctrl_off", 1'b1, 32'hF000_0008, 32'd0, rd);
    applyStimulus("ar_count_wr", 1'b1, 32'hF000_0004, 32'd3, rd);
    applyStimulus("ar_ctrl_wr", 1'b1, 32'hF000_0008, 32'd3, rd);
    cE = lastReadyCyc;
    waitIreq("ar1", cE + 3);
    Iack = 1'b1;
    @(posedge clk);
    #1;
    Iack = 1'b0;
    checkOutput("ar_iack_clear", 32'(Ireq), 32'h0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput("ar_before_set", 32'(Ireq), 32'h0);
    Iack = 1'b1;
    @(posedge clk);
    #1;
    Iack = 1'b0;
    checkOutput("ar_set_wins", 32'(Ireq), 32'h1);
    Iack = 1'b1;
    @(posedge clk);
    #1;
    Iack = 1'b0;
    checkOutput("ar_iack_clear2", 32'(Ireq), 32'h0);
    waitIreq("ar3", cE + 11);
    applyStimulus("ar_disable", 1'b1, 32'hF000_0008, 32'd0, rd);
    applyStimulus("ar_status_clr", 1'b1, 32'hF000_000C, 32'd1, rd);
    checkOutput("ar_status_cleared", 32'(Ireq), 32'h0);
    applyStimulus("ar_ctrl_rd", 1'b0, 32'hF000_0008, 32'h0, rd);
    checkOutput("ar_ctrl_val", rd, 32'h0);

    // Auto-reload with reload value 0 never raises an interrupt
    applyStimulus("z_count_wr", 1'b1, 32'hF000_0004, 32'd0, rd);
    applyStimulus("z_ctrl_wr", 1'b1, 32'hF000_0008, 32'd3, rd);
    repeat (12) @(posedge clk);
    #1;
    checkOutput("z_ireq", 32'(Ireq), 32'h0);
    applyStimulus("z_count_rd", 1'b0, 32'hF000_0004, 32'h0, rd);
    checkOutput("z_count_val", rd, 32'h0);
    applyStimulus("z_ctrl_rd", 1'b0, 32'hF000_0008, 32'h0, rd);
    checkOutput("z_ctrl_val", rd, 32'h3);

    // Reset during RAM_WAIT of a read
    @(negedge clk);
    breq_i = 1'b1;
    mem_w = 1'b0;
    addr_in = 32'h0000_0040;
    @(posedge clk);
    #1;
    checkOutput("rw_ram_addr", 32'(ram_addr), 32'h10);
    #2;
    reset = 1'b0;
    #1;
    breq_i = 1'b0;
    checkOutput("rw_ready", 32'(MIO_ready), 32'h0);
    checkOutput("rw_data", data_to_cpu, 32'h0);
    checkOutput("rw_we", 32'(ram_we), 32'h0);
    checkOutput("rw_ram_addr_rst", 32'(ram_addr), 32'h0);
    checkOutput("rw_ram_din", ram_din, 32'h0);
    checkOutput("rw_led", 32'(led_out), 32'h0);
    checkOutput("rw_ireq", 32'(Ireq), 32'h0);
    sumBad = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (MIO_ready || ram_we) sumBad++;
    end
    checkOutput("rw_no_pulses", 32'(sumBad), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus("resume_rd", 1'b0, 32'h0000_0010, 32'h0, rd);
    checkOutput("resume_data", rd, refMem[4]);
    applyStimulus("resume_ctrl_rd", 1'b0, 32'hF000_0008, 32'h0, rd);
    checkOutput("resume_ctrl", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
